// File: rtl/task_in_frame_buffer.sv
// Single-frame store-and-forward buffer: loads one frame, streams it out with
// backpressure, then holds it for replay until downstream releases it.
module task_in_frame_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int LEN_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tdata_valid,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  i_tdata_last,
    input  logic                  i_output_last,
    input  logic                  i_out_ready,
    input  logic                  i_replay,
    output logic                  o_tready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_enb,
    output logic                  o_last,
    output logic [LEN_WIDTH-1:0]  o_frame_len,
    output logic                  o_overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_WIDTH-1:0] DEPTH_L = LEN_WIDTH'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_DONE} state_t;

    state_t                 state_q, state_d;
    logic                   tready_q, tready_d;
    logic [LEN_WIDTH-1:0]   wr_idx_q, wr_idx_d;
    logic [LEN_WIDTH-1:0]   rd_idx_q, rd_idx_d;
    logic [LEN_WIDTH-1:0]   frame_len_q, frame_len_d;
    logic                   overflow_q, overflow_d;
    logic                   rd_vld_q, rd_vld_d;
    logic                   rd_last_q, rd_last_d;
    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   enb_q, enb_d;
    logic                   last_q, last_d;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic in_xfer, wr_en, adv, issue;

    assign in_xfer = i_tdata_valid && tready_q;
    assign wr_en   = in_xfer && (wr_idx_q < DEPTH_L);
    // Output register frees up when empty or draining; the read stage may only
    // be refilled when its current word can move forward.
    assign adv     = !enb_q || i_out_ready;
    assign issue   = (state_q == SEND) && (rd_idx_q != frame_len_q) && (!rd_vld_q || adv);

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        frame_len_d = frame_len_q;
        overflow_d  = overflow_q;
        rd_vld_d    = rd_vld_q;
        rd_last_d   = rd_last_q;
        data_d      = data_q;
        enb_d       = enb_q;
        last_d      = last_q;

        case (state_q)
            IDLE: begin
                state_d     = LOAD;
                wr_idx_d    = '0;
                rd_idx_d    = '0;
                frame_len_d = '0;
            end
            LOAD: begin
                if (in_xfer) begin
                    if (wr_en) wr_idx_d = wr_idx_q + 1'b1;
                    else       overflow_d = 1'b1;
                    if (i_tdata_last) begin
                        frame_len_d = wr_en ? wr_idx_q + 1'b1 : wr_idx_q;
                        rd_idx_d    = '0;
                        state_d     = SEND;
                    end
                end
            end
            SEND: begin
                if (enb_q && last_q && i_out_ready) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_output_last) begin
                    state_d = IDLE;
                end else if (i_replay) begin
                    state_d  = SEND;
                    rd_idx_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        tready_d = (state_d == LOAD);

        if (issue) begin
            rd_vld_d  = 1'b1;
            rd_last_d = (rd_idx_q == frame_len_q - 1'b1);
            rd_idx_d  = rd_idx_q + 1'b1;
        end else if (adv) begin
            rd_vld_d  = 1'b0;
        end

        if (adv) begin
            enb_d  = rd_vld_q;
            data_d = rd_data_q;
            last_d = rd_last_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            tready_q    <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            frame_len_q <= '0;
            overflow_q  <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            data_q      <= '0;
            enb_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tready_q    <= tready_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            frame_len_q <= frame_len_d;
            overflow_q  <= overflow_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
            data_q      <= data_d;
            enb_q       <= enb_d;
            last_q      <= last_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst) mem_q[wr_idx_q[AW-1:0]] <= i_tdata;
        if (issue)           rd_data_q <= mem_q[rd_idx_q[AW-1:0]];
    end

    assign o_tready    = tready_q;
    assign o_data      = data_q;
    assign o_enb       = enb_q;
    assign o_last      = last_q;
    assign o_frame_len = frame_len_q;
    assign o_overflow  = overflow_q;
endmodule

// File: doc/task_in_frame_buffer.md
TASK_IN_FRAME_BUFFER -- requirements
Module: task_in_frame_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of input and output data words.
REQ-002 Parameter DEPTH, default 256: frame storage capacity in words; power of two, >= 2.
REQ-003 Parameter LEN_WIDTH, default $clog2(DEPTH+1): width of o_frame_len.
REQ-004 Port i_clk  input  1  single clock; all logic on rising edge.
REQ-005 Port i_rst  input  1  synchronous, active-high reset.
REQ-006 Port i_tdata_valid  input  1  input word valid.
REQ-007 Port i_tdata  input  DATA_WIDTH  input word.
REQ-008 Port i_tdata_last  input  1  marks final word of input frame.
REQ-009 Port i_output_last  input  1  downstream finished with current frame; release buffer.
REQ-010 Port i_out_ready  input  1  downstream accepts o_data this cycle.
REQ-011 Port i_replay  input  1  request resend of stored frame.
REQ-012 Port o_tready  output  1  buffer accepting input words.
REQ-013 Port o_data  output  DATA_WIDTH  output word.
REQ-014 Port o_enb  output  1  o_data valid.
REQ-015 Port o_last  output  1  o_data is final word of frame; only meaningful with o_enb.
REQ-016 Port o_frame_len  output  LEN_WIDTH  word count of stored frame.
REQ-017 Port o_overflow  output  1  sticky: a word was dropped because storage was full.

Function
REQ-018 States SHALL be IDLE, LOAD, SEND, WAIT_DONE.
REQ-019 IDLE SHALL go to LOAD on the next cycle unconditionally; write index and o_frame_len cleared to 0.
REQ-020 o_tready SHALL be a register: 1 in every LOAD cycle, 0 in all other states.
REQ-021 Input transfer SHALL occur when i_tdata_valid && o_tready; i_tdata_valid with o_tready=0 ignored.
REQ-022 Each transfer with write index < DEPTH SHALL store i_tdata at the write index and increment it.
REQ-023 Transfer at write index == DEPTH SHALL drop the word and set o_overflow; i_tdata_last on a dropped word still ends the frame.
REQ-024 Transfer with i_tdata_last SHALL latch o_frame_len = stored word count and move to SEND; o_tready=0 from the next cycle.
REQ-025 SEND SHALL read words 0..o_frame_len-1 in order, one-cycle memory read latency, into a registered output stage (o_data, o_enb, o_last).
REQ-026 Output transfer SHALL occur when o_enb && i_out_ready; o_data, o_enb, o_last SHALL hold stable while o_enb && !i_out_ready.
REQ-027 With i_out_ready held 1, o_enb SHALL first be 1 two cycles after the input-last transfer edge, then stay 1 for o_frame_len consecutive cycles.
REQ-028 o_last SHALL be 1 exactly on word o_frame_len-1.
REQ-029 Output transfer of the o_last word SHALL move to WAIT_DONE with o_enb=0 the next cycle.
REQ-030 WAIT_DONE: i_output_last SHALL go to IDLE; otherwise i_replay SHALL go to SEND restarting at word 0 with identical timing; both high: i_output_last wins.
REQ-031 i_output_last and i_replay SHALL be ignored outside WAIT_DONE.
REQ-032 Storage SHALL be inferred memory (no vendor primitives); contents not reset.

Reset
REQ-033 i_rst SHALL, at any state including mid-LOAD or mid-SEND, put state in IDLE and clear o_tready, o_enb, o_last, o_frame_len, o_overflow, o_data to 0, plus indices; i_rst dominates all other inputs.
REQ-034 o_overflow SHALL clear only on reset.
REQ-035 First cycle after reset release: IDLE; o_tready=1 from the second cycle after release.

Verification
REQ-036 Load 5 words 0x11..0x15, last on 0x15, i_out_ready=1 -> o_frame_len=5; o_enb 5 consecutive cycles with 0x11..0x15; o_last on 0x15 only.
REQ-037 Single-word frame 0xA5 with last -> o_frame_len=1; one o_enb cycle, o_data=0xA5, o_last=1.
REQ-038 Frame 1,2,3 with i_out_ready toggling 1,0,0,1,... -> output sequence exactly 1,2,3, data held during stalls, no duplicates.
REQ-039 DEPTH=4, send 6 words, last on 6th -> o_overflow=1, o_frame_len=4, output 4 words with o_last on 4th; o_overflow stays 1 after i_output_last.
REQ-040 In WAIT_DONE pulse i_replay -> same frame resent; then i_replay and i_output_last together -> IDLE, new LOAD, o_tready=1.
REQ-041 Assert i_rst during SEND word 2 -> all outputs 0 next cycle; fresh frame afterward loads and sends correctly.
